// File: rtl/twowayhandshake_replayer_pkg.sv
// Shared replay-side definitions.
// Holds the default payload width, the packet-counter width shared with the
// record-side splitter, and the presentation-state encoding.
package twowayhandshake_replayer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 32;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } present_state_e;

endpackage

// File: rtl/twowayhandshake_replayer_replay_fifo.sv
// replay_fifo: synchronous DATA_WIDTH x DEPTH buffer for replayed begin entries.
// Ports:
//   clk, rst          clock, async active-high reset (pointers only)
//   i_push, i_wr_data write side; ignored when full
//   i_pop             read side; ignored when empty
//   o_full, o_empty   occupancy flags
//   o_head            oldest entry (valid when !o_empty)
module replay_fifo
  import twowayhandshake_replayer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: reads are gated by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/twowayhandshake_replayer.sv
// twowayhandshake_replayer: replays recorded valid/ready transactions to the CL
// and retires replayed end tokens only once the CL has completed a transaction.
// Ports:
//   clk, rst                          clock, async active-high reset
//   rplb_valid/rplb_ready/rplb_data   replayed begin entries in
//   rple_valid/rple_ready             replayed end tokens in
//   out_valid/out_ready/out_data      transactions driven to the CL
//   pend_cnt                          CL completions awaiting an end token
//   done_cnt                          retired (matched) transactions
//   idle                              nothing buffered, presented or pending
//   err_slack                         sticky slack-limit violation
module twowayhandshake_replayer
  import twowayhandshake_replayer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH   = 4,
  parameter int MAX_SLACK   = 15,
  parameter int SLACK_WIDTH = 4,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rplb_valid,
  output logic                   rplb_ready,
  input  logic [DATA_WIDTH-1:0]  rplb_data,
  input  logic                   rple_valid,
  output logic                   rple_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SLACK_WIDTH-1:0] pend_cnt,
  output logic [CNT_WIDTH-1:0]   done_cnt,
  output logic                   idle,
  output logic                   err_slack
);

  localparam logic [SLACK_WIDTH-1:0] LP_MAX     = SLACK_WIDTH'(MAX_SLACK);
  localparam logic [SLACK_WIDTH:0]   LP_MAX_EXT = (SLACK_WIDTH+1)'(MAX_SLACK);

  present_state_e         r_state;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [SLACK_WIDTH-1:0] r_pend;
  logic [CNT_WIDTH-1:0]   r_done;
  logic                   r_err;

  logic                   w_full;
  logic                   w_empty;
  logic [DATA_WIDTH-1:0]  w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fire_out;
  logic                   w_fire_e;
  logic [SLACK_WIDTH:0]   w_pend_inc;
  logic                   w_slack_ok;
  logic                   w_slack_ok_next;

  replay_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (rplb_data),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );

  assign w_fire_out = r_out_valid & out_ready;
  assign w_fire_e   = rple_valid & rple_ready;
  assign rplb_ready = ~w_full & ~rst;
  assign w_push     = rplb_valid & rplb_ready;
  assign rple_ready = (r_pend != '0);

  // Slack gate only decides whether to launch the next entry; a transaction
  // already presented is never withdrawn. The next-entry check is conservative
  // and ignores a same-cycle end token.
  assign w_pend_inc      = {1'b0, r_pend} + (SLACK_WIDTH+1)'(1);
  assign w_slack_ok      = (r_pend < LP_MAX);
  assign w_slack_ok_next = (w_pend_inc < LP_MAX_EXT);
  assign w_pop = ~w_empty &
                 ((r_state == ST_IDLE) ? w_slack_ok : (w_fire_out & w_slack_ok_next));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_out_data  <= w_head;
            r_out_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (w_fire_out) begin
            if (w_pop) begin
              r_out_data <= w_head;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
    end else begin
      case ({w_fire_out, w_fire_e})
        2'b10:   if (r_pend != LP_MAX) r_pend <= r_pend + SLACK_WIDTH'(1);
        2'b01:   r_pend <= r_pend - SLACK_WIDTH'(1);
        default: r_pend <= r_pend;
      endcase
      if (w_fire_e) r_done <= r_done + CNT_WIDTH'(1);
      if (w_fire_out && !w_fire_e && (r_pend == LP_MAX)) r_err <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign pend_cnt  = r_pend;
  assign done_cnt  = r_done;
  assign err_slack = r_err;
  assign idle      = w_empty & ~r_out_valid & (r_pend == '0);

endmodule

// File: tb/tb_twowayhandshake_replayer.sv
module tb_twowayhandshake_replayer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rplb_valid = 1'b0;
  logic        rplb_ready;
  logic [31:0] rplb_data = '0;
  logic        rple_valid = 1'b0;
  logic        rple_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  pend_cnt;
  logic [31:0] done_cnt;
  logic        idle;
  logic        err_slack;

  int n_cmp = 0;
  int n_err = 0;

  twowayhandshake_replayer dut (
    .clk        (clk),
    .rst        (rst),
    .rplb_valid (rplb_valid),
    .rplb_ready (rplb_ready),
    .rplb_data  (rplb_data),
    .rple_valid (rple_valid),
    .rple_ready (rple_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .pend_cnt   (pend_cnt),
    .done_cnt   (done_cnt),
    .idle       (idle),
    .err_slack  (err_slack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rplb_valid = 1'b0;
    rplb_data  = '0;
    rple_valid = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, fe, maxp, bad, pushed, errseen, hs2, rr_n, rr_c, hs_c, hit, seen;

    // reset state
    #2;
    chk("rst_rplb_ready", rplb_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rple_ready", rple_ready, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_err", err_slack, 0);
    chk("rst_idle", idle, 1);

    // single transaction
    do_reset();
    rplb_valid = 1'b1; rplb_data = 32'hA5A5_0001; out_ready = 1'b1;
    #1 chk("t1_c0_rplb_ready", rplb_ready, 1);
    tick(); rplb_valid = 1'b0;
    #1 chk("t1_c1_out_valid", out_valid, 0);
    tick();
    #1 chk("t1_c2_out_valid", out_valid, 1);
    chk("t1_c2_out_data", out_data, 32'hA5A5_0001);
    tick();
    #1 chk("t1_c3_out_valid", out_valid, 0);
    chk("t1_c3_pend", pend_cnt, 1);
    chk("t1_c3_rple_ready", rple_ready, 1);
    tick();
    #1 chk("t1_c4_pend", pend_cnt, 1);
    tick(); rple_valid = 1'b1;
    #1 chk("t1_c5_rple_ready", rple_ready, 1);
    tick(); rple_valid = 1'b0;
    #1 chk("t1_c6_pend", pend_cnt, 0);
    chk("t1_c6_done", done_cnt, 1);
    chk("t1_c6_idle", idle, 1);

    // back-to-back with end tokens always offered
    do_reset();
    out_ready = 1'b1; rple_valid = 1'b1;
    hs = 0; fe = 0; maxp = 0;
    for (int c = 0; c < 12; c++) begin
      rplb_valid = (c < 4);
      rplb_data  = c + 1;
      #1;
      if (out_valid && out_ready) begin
        chk("b2b_data", out_data, hs + 1);
        chk("b2b_hs_cycle", c, hs + 2);
        hs++;
      end
      if (rple_valid && rple_ready) begin
        chk("b2b_e_cycle", c, fe + 3);
        fe++;
      end
      if (int'(pend_cnt) > maxp) maxp = int'(pend_cnt);
      tick();
    end
    rple_valid = 1'b0;
    chk("b2b_hs_count", hs, 4);
    chk("b2b_e_count", fe, 4);
    chk("b2b_max_pend", maxp, 1);
    chk("b2b_done", done_cnt, 4);
    chk("b2b_idle", idle, 1);

    // CL backpressure
    do_reset();
    out_ready = 1'b0; rple_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rplb_valid = 1'b1;
      rplb_data  = 32'h10 + c;
      #1 chk("bp_push_ready", rplb_ready, 1);
      tick();
    end
    rplb_valid = 1'b0;
    #1 chk("bp_full_ready", rplb_ready, 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (!(out_valid === 1'b1 && out_data === 32'h10)) bad++;
      tick();
    end
    chk("bp_frozen_bad_cycles", bad, 0);
    out_ready = 1'b1; rple_valid = 1'b1;
    hs = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (out_valid && out_ready) begin
        chk("bp_drain_data", out_data, 32'h10 + hs);
        hs++;
      end
      tick();
    end
    rple_valid = 1'b0;
    chk("bp_drain_count", hs, 5);
    chk("bp_done", done_cnt, 5);
    chk("bp_idle", idle, 1);

    // missing end tokens: slack limit
    do_reset();
    out_ready = 1'b1; rple_valid = 1'b0;
    pushed = 0; hs = 0; errseen = 0;
    for (int c = 0; c < 80; c++) begin
      rplb_valid = (pushed < 20);
      rplb_data  = pushed;
      #1;
      if (rplb_valid && rplb_ready) pushed++;
      if (out_valid && out_ready) hs++;
      if (err_slack) errseen = 1;
      tick();
    end
    chk("slack_hs_count", hs, 15);
    chk("slack_out_valid", out_valid, 0);
    chk("slack_pend", pend_cnt, 15);
    rplb_valid = 1'b0;
    rple_valid = 1'b1;
    #1 chk("slack_token_ready", rple_ready, 1);
    tick();
    rple_valid = 1'b0;
    hs2 = 0;
    for (int c = 0; c < 30; c++) begin
      rplb_valid = (pushed < 20);
      rplb_data  = pushed;
      #1;
      if (rplb_valid && rplb_ready) pushed++;
      if (out_valid && out_ready) hs2++;
      if (err_slack) errseen = 1;
      tick();
    end
    rplb_valid = 1'b0;
    chk("slack_extra_hs", hs2, 1);
    chk("slack_pend_after", pend_cnt, 15);
    chk("slack_done", done_cnt, 1);
    chk("slack_err_seen", errseen, 0);

    // early end token
    do_reset();
    rple_valid = 1'b1; out_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (rple_ready !== 1'b0) bad++;
      tick();
    end
    chk("early_ready_before_push", bad, 0);
    rr_n = 0; rr_c = -100; hs_c = -200;
    for (int c = 0; c < 10; c++) begin
      rplb_valid = (c == 0);
      rplb_data  = 32'h55;
      #1;
      if (out_valid && out_ready) hs_c = c;
      if (rple_ready) begin
        rr_n++;
        rr_c = c;
      end
      tick();
    end
    rple_valid = 1'b0;
    chk("early_ready_pulses", rr_n, 1);
    chk("early_ready_cycle", rr_c, hs_c + 1);
    chk("early_done", done_cnt, 1);

    // reset mid-transfer
    do_reset();
    out_ready = 1'b1; rple_valid = 1'b0;
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      rplb_valid = (c < 4);
      rplb_data  = 32'h20 + c;
      #1;
      if (pend_cnt == 4'd3 && out_valid) begin
        hit = 1;
        out_ready = 1'b0;
        break;
      end
      tick();
    end
    rplb_valid = 1'b0;
    chk("mid_reached_pend3", hit, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_pend", pend_cnt, 0);
    chk("mid_done", done_cnt, 0);
    chk("mid_idle", idle, 1);
    chk("mid_rplb_ready", rplb_ready, 0);
    tick();
    rst = 1'b0;
    rplb_valid = 1'b1; rplb_data = 32'h77; out_ready = 1'b1;
    tick();
    rplb_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        seen = 1;
        chk("mid_replay_data", out_data, 32'h77);
        break;
      end
      tick();
    end
    chk("mid_replay_seen", seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
